// File: rtl/agc_pwm_ctrl.sv
// AGC loop controller: steps a PWM gain code toward the requested power, locks when settled.
// Optional PWM waveform output is built only when AGC_PWM_OUT_EN is defined.
//
// state | meaning
// IDLE  | loop disabled or threshold forced; pwm_val follows pwm_th_in
// ACQ   | acquiring; each estimate steps pwm_val, counts in-window hits
// LOCK  | pwm_val held; counts out-of-coarse-window estimates for unlock
module agc_pwm_ctrl #(
    parameter int PW         = 8,
    parameter int DW         = 9,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] pwr_req_val,
    input  logic [DW-1:0] pwr_est_dB,
    input  logic          pwr_est_end,
    input  logic          pwm_ena,
    input  logic          pwm_inv,
    input  logic          pwm_th_ena,
    input  logic          relock_en,
    input  logic [PW-1:0] pwm_th_in,
    input  logic [PW-1:0] pwm_min_val,
    input  logic [PW-1:0] pwm_max_val,
    input  logic [3:0]    step_fine,
    input  logic [3:0]    step_coarse,
    input  logic [DW-1:0] win_fine,
    input  logic [DW-1:0] win_coarse,
    output logic [PW-1:0] pwm_val,
    output logic          pwm_val_up,
    output logic          agc_fix,
    output logic [1:0]    agc_state,
    output logic          pwm_out
);

    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);
    localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_CNT);
    localparam logic [UW-1:0] UNLOCK_LAST = UW'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACQ  = 2'b01,
        LOCK = 2'b10
    } state_t;

    state_t        state;
    logic [LW-1:0] lock_cnt;
    logic [UW-1:0] unlock_cnt;

    logic [DW:0]   delta;
    logic [DW-1:0] abs_err;
    logic          in_fine;
    logic          out_coarse;
    logic [3:0]    step;
    logic          dir_up;
    logic [PW:0]   sum_up;
    logic [PW:0]   sum_dn;
    logic [PW-1:0] val_next;
    logic          go_idle;
    logic [LW-1:0] lock_inc;
    logic [UW-1:0] unlock_sat;

    always_comb begin
        delta      = {1'b0, pwr_req_val} - {1'b0, pwr_est_dB};
        abs_err    = delta[DW] ? DW'(-delta) : delta[DW-1:0];
        in_fine    = (abs_err <= win_fine);
        out_coarse = (abs_err > win_coarse);
        step       = in_fine ? 4'd0 : (out_coarse ? step_coarse : step_fine);
        dir_up     = ~delta[DW] ^ pwm_inv;
        sum_up     = {1'b0, pwm_val} + {{(PW-3){1'b0}}, step};
        sum_dn     = {1'b0, pwm_val} - {{(PW-3){1'b0}}, step};

        // An inverted clamp range collapses onto the upper limit.
        if (pwm_min_val > pwm_max_val) begin
            val_next = pwm_max_val;
        end else if (dir_up) begin
            if (sum_up > {1'b0, pwm_max_val})
                val_next = pwm_max_val;
            else if (sum_up[PW-1:0] < pwm_min_val)
                val_next = pwm_min_val;
            else
                val_next = sum_up[PW-1:0];
        end else begin
            if (sum_dn[PW] || (sum_dn[PW-1:0] < pwm_min_val))
                val_next = pwm_min_val;
            else if (sum_dn[PW-1:0] > pwm_max_val)
                val_next = pwm_max_val;
            else
                val_next = sum_dn[PW-1:0];
        end

        go_idle    = ~pwm_ena | pwm_th_ena;
        lock_inc   = lock_cnt + 1'b1;
        unlock_sat = (unlock_cnt == UNLOCK_LAST) ? unlock_cnt : unlock_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pwm_val    <= '0;
            pwm_val_up <= 1'b0;
            agc_fix    <= 1'b0;
            lock_cnt   <= '0;
            unlock_cnt <= '0;
        end else begin
            pwm_val_up <= 1'b0;
            if (go_idle) begin
                state      <= IDLE;
                pwm_val    <= pwm_th_in;
                agc_fix    <= 1'b0;
                lock_cnt   <= '0;
                unlock_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        // Estimates arriving on the entry cycle are dropped.
                        state      <= ACQ;
                        pwm_val    <= pwm_th_in;
                        agc_fix    <= 1'b0;
                        lock_cnt   <= '0;
                        unlock_cnt <= '0;
                    end
                    ACQ: begin
                        if (pwr_est_end) begin
                            pwm_val_up <= 1'b1;
                            pwm_val    <= val_next;
                            if (in_fine) begin
                                if (lock_inc == LOCK_LAST) begin
                                    state    <= LOCK;
                                    agc_fix  <= 1'b1;
                                    lock_cnt <= '0;
                                end else begin
                                    lock_cnt <= lock_inc;
                                end
                            end else begin
                                lock_cnt <= '0;
                            end
                        end
                    end
                    LOCK: begin
                        if (pwr_est_end) begin
                            pwm_val_up <= 1'b1;
                            if (in_fine) begin
                                unlock_cnt <= '0;
                            end else if (out_coarse) begin
                                if ((unlock_sat == UNLOCK_LAST) && relock_en) begin
                                    state      <= ACQ;
                                    agc_fix    <= 1'b0;
                                    lock_cnt   <= '0;
                                    unlock_cnt <= '0;
                                end else begin
                                    unlock_cnt <= unlock_sat;
                                end
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        agc_fix <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign agc_state = state;

`ifdef AGC_PWM_OUT_EN
    logic [PW-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm_out <= (pwm_cnt < pwm_val);
        end
    end
`else
    assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_agc_pwm_ctrl.sv
// Bench for agc_pwm_ctrl: directed scenarios plus randomized traffic against a queue scoreboard.
// Works with or without AGC_PWM_OUT_EN defined.
module tb_agc_pwm_ctrl;
    localparam int PW = 8;
    localparam int DW = 9;
    localparam int LOCK_CNT = 4;
    localparam int UNLOCK_CNT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [DW-1:0] pwr_req_val, pwr_est_dB;
    logic          pwr_est_end, pwm_ena, pwm_inv, pwm_th_ena, relock_en;
    logic [PW-1:0] pwm_th_in, pwm_min_val, pwm_max_val;
    logic [3:0]    step_fine, step_coarse;
    logic [DW-1:0] win_fine, win_coarse;
    logic [PW-1:0] pwm_val;
    logic          pwm_val_up, agc_fix, pwm_out;
    logic [1:0]    agc_state;

    agc_pwm_ctrl #(.PW(PW), .DW(DW), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut (
        .clk(clk), .reset_n(reset_n),
        .pwr_req_val(pwr_req_val), .pwr_est_dB(pwr_est_dB), .pwr_est_end(pwr_est_end),
        .pwm_ena(pwm_ena), .pwm_inv(pwm_inv), .pwm_th_ena(pwm_th_ena), .relock_en(relock_en),
        .pwm_th_in(pwm_th_in), .pwm_min_val(pwm_min_val), .pwm_max_val(pwm_max_val),
        .step_fine(step_fine), .step_coarse(step_coarse),
        .win_fine(win_fine), .win_coarse(win_coarse),
        .pwm_val(pwm_val), .pwm_val_up(pwm_val_up), .agc_fix(agc_fix),
        .agc_state(agc_state), .pwm_out(pwm_out)
    );

    typedef struct { int val; int state; } exp_t;
    exp_t sb_q[$];

    int compared = 0;
    int mismatched = 0;

    // Reference model: state 0 idle, 1 acquiring, 2 locked.
    int m_state, m_val, m_lock, m_unlock, m_cnt, m_pout;
    int m_up;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_val = 0; m_lock = 0; m_unlock = 0;
        m_cnt = 0; m_pout = 0; m_up = 0;
    endtask

    function automatic int model_next_val(input int err);
        int ae, st, v;
        ae = (err < 0) ? -err : err;
        if (ae <= int'(win_fine)) st = 0;
        else if (ae > int'(win_coarse)) st = int'(step_coarse);
        else st = int'(step_fine);
        if ((err >= 0) != (pwm_inv == 1'b1)) v = m_val + st;
        else v = m_val - st;
        if (pwm_min_val > pwm_max_val) return int'(pwm_max_val);
        if (v > int'(pwm_max_val)) return int'(pwm_max_val);
        if (v < int'(pwm_min_val)) return int'(pwm_min_val);
        return v;
    endfunction

    // Applies the current inputs to the model as if at the coming rising edge.
    task automatic model_edge();
        int err, ae;
        m_up = 0;
        if (!reset_n) begin
            model_reset();
            return;
        end
`ifdef AGC_PWM_OUT_EN
        m_pout = (m_cnt < m_val) ? 1 : 0;
        m_cnt  = (m_cnt + 1) % (1 << PW);
`endif
        if (!pwm_ena || pwm_th_ena) begin
            m_state = 0; m_val = int'(pwm_th_in); m_lock = 0; m_unlock = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_val = int'(pwm_th_in); m_lock = 0; m_unlock = 0;
        end else if (pwr_est_end) begin
            err = int'(pwr_req_val) - int'(pwr_est_dB);
            ae  = (err < 0) ? -err : err;
            m_up = 1;
            if (m_state == 1) begin
                m_val = model_next_val(err);
                if (ae <= int'(win_fine)) begin
                    m_lock++;
                    if (m_lock == LOCK_CNT) begin
                        m_state = 2; m_lock = 0;
                    end
                end else begin
                    m_lock = 0;
                end
            end else begin
                if (ae <= int'(win_fine)) begin
                    m_unlock = 0;
                end else if (ae > int'(win_coarse)) begin
                    if (m_unlock < UNLOCK_CNT) m_unlock++;
                    if (m_unlock == UNLOCK_CNT && relock_en) begin
                        m_state = 1; m_lock = 0; m_unlock = 0;
                    end
                end
            end
            sb_q.push_back('{val: m_val, state: m_state});
        end
    endtask

    task automatic check_cycle();
        chk("val", int'(pwm_val), m_val);
        chk("state", int'(agc_state), m_state);
        chk("fix", int'(agc_fix), (m_state == 2) ? 1 : 0);
        chk("up", int'(pwm_val_up), m_up);
        chk("pwm_out", int'(pwm_out), m_pout);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic est(input int req, input int e);
        pwr_req_val = DW'(req);
        pwr_est_dB  = DW'(e);
        pwr_est_end = 1'b1;
        tick();
        pwr_est_end = 1'b0;
    endtask

    task automatic preset(input int v);
        pwm_th_in  = PW'(v);
        pwm_th_ena = 1'b1;
        tick();
        pwm_th_ena = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_val", int'(pwm_val), 0);
        chk("rst_up", int'(pwm_val_up), 0);
        chk("rst_fix", int'(agc_fix), 0);
        chk("rst_state", int'(agc_state), 0);
        chk("rst_pwm_out", int'(pwm_out), 0);
        model_reset();
        sb_q.delete();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic cfg_default();
        pwm_inv = 1'b0; relock_en = 1'b1;
        pwm_min_val = 8'h00; pwm_max_val = 8'hFF;
        step_fine = 4'd1; step_coarse = 4'd8;
        win_fine = 9'd5; win_coarse = 9'd40;
        pwr_est_end = 1'b0; pwm_th_ena = 1'b0;
    endtask

    task automatic lock_up();
        for (int i = 0; i < LOCK_CNT; i++) begin
            est(100, 103);
            tick();
        end
    endtask

    // Scoreboard monitor: every update strobe must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (pwm_val_up) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_up", int'(pwm_val_up), 0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_val", int'(pwm_val), e.val);
                chk("sb_state", int'(agc_state), e.state);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int hi, req, mag, b, e;
        reset_n = 1'b0;
        pwr_req_val = '0; pwr_est_dB = '0; pwm_ena = 1'b0;
        pwm_th_in = 8'h80;
        cfg_default();
        model_reset();
        #1;
        chk("rst_val", int'(pwm_val), 0);
        chk("rst_state", int'(agc_state), 0);
        tick();
        tick();
        reset_n = 1'b1;

        // Coarse step up from preset
        tick();
        pwm_ena = 1'b1;
        tick();
        chk("acq_entry_state", int'(agc_state), 1);
        est(200, 100);
        chk("coarse_up_val", int'(pwm_val), 8'h88);
        chk("coarse_up_pulse", int'(pwm_val_up), 1);
        tick();
        chk("pulse_one_cycle", int'(pwm_val_up), 0);

        // Inverted polarity, fine step
        preset(8'h40);
        pwm_inv = 1'b1;
        est(100, 120);
        chk("inv_fine_val", int'(pwm_val), 8'h41);
        pwm_inv = 1'b0;

        // Clamps
        pwm_max_val = 8'hF0;
        preset(8'hEE);
        est(200, 100);
        chk("clamp_max", int'(pwm_val), 8'hF0);
        pwm_max_val = 8'hFF;
        pwm_min_val = 8'h10;
        preset(8'h12);
        est(100, 200);
        chk("clamp_min", int'(pwm_val), 8'h10);
        pwm_min_val = 8'hA0;
        pwm_max_val = 8'h90;
        preset(8'h50);
        est(100, 103);
        chk("min_gt_max", int'(pwm_val), 8'h90);
        cfg_default();

        // Lock then unlock with relock enabled
        preset(8'h80);
        for (int i = 0; i < LOCK_CNT; i++) begin
            est(100, 103);
            if (i == LOCK_CNT - 2) chk("no_lock_early", int'(agc_state), 1);
            tick();
        end
        chk("lock_state", int'(agc_state), 2);
        chk("lock_fix", int'(agc_fix), 1);
        for (int i = 0; i < UNLOCK_CNT; i++) begin
            est(100, 150);
            if (i == UNLOCK_CNT - 2) chk("no_unlock_early", int'(agc_state), 2);
            tick();
        end
        chk("unlock_state", int'(agc_state), 1);
        chk("unlock_fix", int'(agc_fix), 0);

        // Between-window estimate leaves the unlock count alone
        lock_up();
        est(100, 150); est(100, 150); est(100, 120); est(100, 150);
        chk("between_keeps_cnt", int'(agc_state), 1);
        // In-window estimate clears it
        lock_up();
        est(100, 150); est(100, 150); est(100, 102); est(100, 150); est(100, 150);
        chk("fine_clears_cnt", int'(agc_state), 2);

        // relock_en=0 keeps LOCK
        preset(8'h80);
        lock_up();
        relock_en = 1'b0;
        for (int i = 0; i < 5; i++) est(100, 150);
        chk("no_relock_state", int'(agc_state), 2);
        relock_en = 1'b1;

        // Enable dropping together with an estimate
        preset(8'h80);
        est(200, 100);
        pwm_th_in = 8'h33;
        pwm_ena = 1'b0;
        pwr_est_end = 1'b1;
        tick();
        pwr_est_end = 1'b0;
        chk("idle_prio_up", int'(pwm_val_up), 0);
        chk("idle_prio_val", int'(pwm_val), 8'h33);
        chk("idle_prio_state", int'(agc_state), 0);
        pwm_ena = 1'b1;
        pwr_est_end = 1'b1;
        tick();
        pwr_est_end = 1'b0;
        chk("entry_ignore_up", int'(pwm_val_up), 0);
        chk("entry_ignore_val", int'(pwm_val), 8'h33);

        // Reset in the middle of acquisition
        est(200, 100);
        do_reset();

        // PWM waveform duty over one period while locked at 0x40
        preset(8'h40);
        lock_up();
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            hi += int'(pwm_out);
        end
`ifdef AGC_PWM_OUT_EN
        chk("pwm_duty", hi, 64);
`else
        chk("pwm_off", hi, 0);
`endif

        // Randomized traffic
        for (int ph = 0; ph < 40; ph++) begin
            pwm_ena = 1'b0;
            pwr_est_end = 1'b0;
            tick();
            pwm_inv     = 1'($urandom % 2);
            relock_en   = 1'($urandom % 2);
            win_fine    = DW'($urandom_range(0, 8));
            win_coarse  = DW'($urandom_range(12, 60));
            step_fine   = 4'($urandom_range(1, 4));
            step_coarse = 4'($urandom_range(4, 15));
            if ($urandom % 5 == 0) begin
                pwm_min_val = PW'($urandom % 256);
                pwm_max_val = PW'($urandom % 256);
            end else begin
                pwm_min_val = PW'($urandom_range(0, 40));
                pwm_max_val = PW'($urandom_range(200, 255));
            end
            pwm_th_in = PW'($urandom % 256);
            pwm_ena = 1'b1;
            for (int c = 0; c < 80; c++) begin
                pwm_ena     = ($urandom % 50) != 0;
                pwm_th_ena  = ($urandom % 60) == 0;
                pwr_est_end = ($urandom % 3) == 0;
                req = $urandom_range(100, 400);
                b = $urandom % 10;
                if (b < 5) mag = $urandom_range(0, int'(win_fine));
                else if (b < 7) mag = $urandom_range(int'(win_fine) + 1, int'(win_coarse));
                else mag = $urandom_range(int'(win_coarse) + 1, 99);
                e = ($urandom % 2) ? req + mag : req - mag;
                pwr_req_val = DW'(req);
                pwr_est_dB  = DW'(e);
                tick();
            end
            pwm_th_ena = 1'b0;
            pwr_est_end = 1'b0;
            if (ph % 10 == 9) do_reset();
        end

        pwr_est_end = 1'b0;
        tick();
        tick();
        chk("sb_drain", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/agc_pwm_ctrl.md
AGC_PWM_CTRL -- requirements
Module: agc_pwm_ctrl

Interface
REQ-001 SHALL have parameter PW, 8, width of PWM code and PWM counter.
REQ-002 SHALL have parameter DW, 9, width of power values (0.125 dB/LSB).
REQ-003 SHALL have parameter LOCK_CNT, 4, consecutive in-window estimates required to lock.
REQ-004 SHALL have parameter UNLOCK_CNT, 3, consecutive out-of-coarse-window estimates required to unlock.
REQ-005 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports pwr_req_val, pwr_est_dB  in  DW  target power and estimated power, unsigned.
REQ-008 SHALL have port pwr_est_end  in  1  one-cycle strobe, pwr_est_dB valid.
REQ-009 SHALL have ports pwm_ena, pwm_inv, pwm_th_ena, relock_en  in  1  loop enable, gain-polarity invert, force threshold, allow unlock.
REQ-010 SHALL have ports pwm_th_in, pwm_min_val, pwm_max_val  in  PW  preset code, lower clamp, upper clamp.
REQ-011 SHALL have ports step_fine, step_coarse  in  4  fine and coarse step sizes.
REQ-012 SHALL have ports win_fine, win_coarse  in  DW  lock window and coarse-step threshold.
REQ-013 SHALL have outputs pwm_val  PW, pwm_val_up  1, agc_fix  1, agc_state  2 (00 IDLE, 01 ACQ, 10 LOCK), pwm_out  1.

Function
REQ-014 SHALL compute delta = req - est as DW+1-bit two's complement and abs_err = |delta| in DW bits, combinationally.
REQ-015 SHALL use state IDLE whenever pwm_ena=0 or pwm_th_ena=1; in IDLE, pwm_val loads pwm_th_in every cycle and all event counters clear.
REQ-016 SHALL move IDLE->ACQ on the first cycle pwm_ena=1 and pwm_th_ena=0.
REQ-017 SHALL, in ACQ on pwr_est_end at cycle T, register the new pwm_val visible from cycle T+1.
REQ-018 SHALL select the step as: abs_err<=win_fine -> 0; abs_err>win_coarse -> step_coarse; otherwise step_fine.
REQ-019 SHALL set direction: delta<0 decrements, delta>=0 increments; pwm_inv=1 swaps the two.
REQ-020 SHALL compute sums in PW+1 bits and clamp the result to [pwm_min_val, pwm_max_val]; with min>max the result is pwm_max_val.
REQ-021 SHALL, in ACQ, increment the lock counter per in-window estimate (abs_err<=win_fine), clear it on any other estimate, and go to LOCK when it reaches LOCK_CNT.
REQ-022 SHALL hold pwm_val in LOCK; agc_fix=1 exactly while state is LOCK.
REQ-023 SHALL, in LOCK, increment the unlock counter per estimate with abs_err>win_coarse and clear it on abs_err<=win_fine; estimates between the windows leave it unchanged.
REQ-024 SHALL go LOCK->ACQ with both counters cleared when the unlock counter reaches UNLOCK_CNT and relock_en=1; with relock_en=0, remain in LOCK and saturate the counter.
REQ-025 SHALL pulse pwm_val_up for one cycle at T+1 for every pwr_est_end at T processed in ACQ or LOCK, including zero-step estimates; it is never asserted in IDLE.
REQ-026 SHALL give IDLE conditions priority over a coincident pwr_est_end: no update and no pwm_val_up.
REQ-027 SHALL ignore pwr_est_end during the IDLE->ACQ transition cycle.

Reset
REQ-028 SHALL, on reset_n low, asynchronously set pwm_val=0, pwm_val_up=0, agc_fix=0, agc_state=IDLE, pwm_out=0, both counters=0, PWM counter=0.
REQ-029 SHALL, after reset release, behave as if freshly in IDLE, even if reset was asserted mid-acquisition.

Configuration
REQ-030 SHALL compile a PWM waveform generator when macro AGC_PWM_OUT_EN is defined: a free-running PW-bit counter wrapping 2^PW-1->0, with registered pwm_out = (counter < pwm_val).
REQ-031 SHALL, without AGC_PWM_OUT_EN, tie pwm_out to 0 and omit the counter; all other behaviour is identical.

Verification
REQ-032 SHALL cover PW=8, th_in=0x80, ena, req=200, est=100 (err 100>win_coarse=40, step_coarse=8) -> pwm_val 0x88 at T+1, pwm_val_up pulse at T+1.
REQ-033 SHALL cover pwm_inv=1, req=100, est=120 (err 20, win_fine=5, step_fine=1) from pwm_val 0x40 -> pwm_val 0x41.
REQ-034 SHALL cover clamp: max=0xF0, pwm_val 0xEE, step 8 up -> 0xF0; min=0x10, pwm_val 0x12, step 8 down -> 0x10.
REQ-035 SHALL cover 4 consecutive estimates with err 3 -> agc_fix=1, agc_state=10; then 3 estimates with err 50 and relock_en=1 -> agc_state=01, agc_fix=0; with relock_en=0 -> stays LOCK.
REQ-036 SHALL cover pwm_ena falling coincident with pwr_est_end -> no pwm_val_up, pwm_val=pwm_th_in next cycle, and reset asserted in ACQ -> all outputs 0.
REQ-037 SHALL cover, with AGC_PWM_OUT_EN, pwm_val=0x40 held in LOCK -> pwm_out high exactly 64 of every 256 cycles.
